// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word RAM controller arbitrating processor loads/stores against a host port
module data_mem_ctrl #(
  parameter int AW = 12,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          mem_read,
  input  logic          mem_write,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_ack
);
  localparam logic [2:0] IDLE = 3'd0, RD_ADDR = 3'd1, RD_DATA = 3'd2, WR = 3'd3, DONE = 3'd4;
  logic [2:0]    state_q, state_d;
  logic          src_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, ram_q, rdata_q, ext_rdata_q;
  logic          err_q;
  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic          proc_req, accept, nxt_we;
  assign proc_req = mem_read | mem_write;
  assign accept   = (state_q == IDLE) && (proc_req || ext_req);
  // a processor collision is served as a write
  assign nxt_we   = proc_req ? mem_write : ext_we;
  always_comb begin
    state_d = state_q == IDLE    ? (accept ? (nxt_we ? WR : RD_ADDR) : IDLE) :
              state_q == RD_ADDR ? RD_DATA :
              state_q == RD_DATA ? DONE :
              state_q == WR      ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      ext_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q   <= ~proc_req;
        addr_q  <= proc_req ? addr : ext_addr;
        wdata_q <= proc_req ? wdata : ext_wdata;
        err_q   <= err_q | (mem_read & mem_write);
      end
      if (state_q == RD_DATA && src_q) ext_rdata_q <= ram_q;
      if (state_q == RD_DATA && !src_q) rdata_q <= ram_q;
    end
  end
  // RAM is never cleared; a reset on the WR exit edge drops the write
  always_ff @(posedge clk) begin
    if (!rst && state_q == WR) mem_q[addr_q] <= wdata_q;
    if (state_q == RD_ADDR) ram_q <= mem_q[addr_q];
  end
  assign rdata     = rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign err       = err_q;
  assign busy      = state_q != IDLE;
  assign done      = (state_q == DONE) && !src_q;
  assign ext_ack   = (state_q == DONE) && src_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench with a behavioural memory model and randomized traffic
module tb_data_mem_ctrl;
  logic        clk = 0, rst = 1;
  logic [11:0] addr = 0, ext_addr = 0;
  logic [9:0]  wdata = 0, ext_wdata = 0, rdata, ext_rdata;
  logic        mem_read = 0, mem_write = 0, ext_req = 0, ext_we = 0;
  logic        busy, done, err, ext_ack;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [9:0] r; logic [9:0] x; logic e;} exp_t;
  exp_t pq[$], hq[$];
  logic [9:0] ref_mem [int];
  int keys[$];
  logic [9:0] m_r = 0, m_x = 0;
  logic m_e = 0;

  data_mem_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_read(mem_read),
    .mem_write(mem_write), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input bit host, input bit rd, input bit wr, input logic [11:0] a, input logic [9:0] d);
    if (!host && rd && wr) m_e = 1;
    if (wr) begin
      ref_mem[int'(a)] = d;
      if (!(int'(a) inside {keys})) keys.push_back(int'(a));
    end else if (host) m_x = ref_mem[int'(a)];
    else m_r = ref_mem[int'(a)];
    if (host) hq.push_back('{m_r, m_x, m_e});
    else pq.push_back('{m_r, m_x, m_e});
  endtask

  task automatic drive_proc(input bit rd, input bit wr, input logic [11:0] a, input logic [9:0] d, input int lat);
    int n = 0;
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    chk(rd && !wr ? "proc_read_latency" : "proc_write_latency", n, lat);
    mem_read = 0; mem_write = 0;
    @(negedge clk);
  endtask

  task automatic drive_host(input bit we, input logic [11:0] a, input logic [9:0] d, input int lat);
    int n = 0;
    ext_req = 1; ext_we = we; ext_addr = a; ext_wdata = d;
    do begin @(negedge clk); n++; end while (!ext_ack && n < 20);
    chk(we ? "host_write_latency" : "host_read_latency", n, lat);
    ext_req = 0;
    @(negedge clk);
  endtask

  task automatic proc_op(input bit rd, input bit wr, input logic [11:0] a, input logic [9:0] d);
    issue(0, rd, wr, a, d);
    drive_proc(rd, wr, a, d, (rd && !wr) ? 3 : 2);
  endtask

  task automatic host_op(input bit we, input logic [11:0] a, input logic [9:0] d);
    issue(1, !we, we, a, d);
    drive_host(we, a, d, we ? 2 : 3);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (done && ext_ack) chk("done_and_ack_together", 1, 0);
      if (done) begin
        if (pq.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = pq.pop_front();
          chk("done_rdata", int'(rdata), int'(e.r));
          chk("done_ext_rdata", int'(ext_rdata), int'(e.x));
          chk("done_err", int'(err), int'(e.e));
        end
      end
      if (ext_ack) begin
        if (hq.size() == 0) chk("spurious_ext_ack", 1, 0);
        else begin
          e = hq.pop_front();
          chk("ack_rdata", int'(rdata), int'(e.r));
          chk("ack_ext_rdata", int'(ext_rdata), int'(e.x));
          chk("ack_err", int'(err), int'(e.e));
        end
      end
    end
  end

  initial begin
    int arb_p = 0, arb_h = 0, cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", int'(rdata), 0);
    chk("reset_ext_rdata", int'(ext_rdata), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ext_ack", int'(ext_ack), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    rst = 0;
    @(negedge clk);
    host_op(1, 12'h010, 10'h2A5);
    proc_op(1, 0, 12'h010, 0);
    proc_op(0, 1, 12'hFFF, 10'h3FF);
    host_op(0, 12'hFFF, 0);
    host_op(1, 12'h001, 10'h0AB);
    issue(0, 1, 0, 12'h001, 0);
    issue(1, 1, 0, 12'h010, 0);
    fork
      begin drive_proc(1, 0, 12'h001, 0, 3); arb_p = $time; end
      begin
        ext_req = 1; ext_we = 0; ext_addr = 12'h010;
        do begin @(negedge clk); cyc++; end while (!ext_ack && cyc < 30);
        arb_h = $time;
        chk("arb_host_timeout", int'(cyc < 30), 1);
        ext_req = 0;
        @(negedge clk);
      end
    join
    chk("arb_host_after_proc", int'(arb_h > arb_p - 10), 1);
    proc_op(1, 1, 12'h020, 10'h155);
    proc_op(1, 0, 12'h020, 0);
    proc_op(0, 1, 12'h030, 10'h111);
    mem_write = 1; addr = 12'h030; wdata = 10'h222;
    @(negedge clk);
    chk("midwrite_busy", int'(busy), 1);
    rst = 1; mem_write = 0;
    @(negedge clk);
    chk("midwrite_abort_busy", int'(busy), 0);
    chk("midwrite_abort_done", int'(done), 0);
    rst = 0;
    m_r = 0; m_x = 0; m_e = 0;
    chk("midwrite_err_cleared", int'(err), 0);
    chk("midwrite_rdata_cleared", int'(rdata), 0);
    @(negedge clk);
    proc_op(1, 0, 12'h030, 0);
    for (int i = 0; i < 40; i++) begin
      bit host = 1'($urandom);
      bit wr = (keys.size() == 0) || ($urandom_range(0, 2) == 0);
      logic [11:0] a = wr ? 12'($urandom) : 12'(keys[$urandom_range(0, keys.size() - 1)]);
      logic [9:0] d = 10'($urandom);
      if (host) host_op(wr, a, d);
      else proc_op(!wr || ($urandom_range(0, 4) == 0), wr, a, d);
    end
    repeat (4) @(negedge clk);
    chk("proc_queue_drained", pq.size(), 0);
    chk("host_queue_drained", hq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
